soc_node_rd_arbiter: RTL
========================

Name: soc_node_rd_arbiter

Overview:
- Round-robin arbiter sharing one AXI read port (AR/R) of the SoC interconnect node among N requesters (external, cluster, SPI, I2C slave paths).
- Sequences AR grants and extends the AXI ID with the source index.
- Routes R beats back to the requester by ID MSBs and limits outstanding bursts per source.
- Sits between the requester slave ports and the ext-to-SoC crossbar input.

Parameters:
- N_SRC, 4, number of requesters; legal range 2..8.
- IW_INP, 6, requester AXI ID width.
- AW, 32, address width.
- DW, 64, data width.
- MAX_OUTST, 8, maximum outstanding read bursts per source; legal range 1..255.
- Derived: SW = $clog2(N_SRC); IW_OUP = IW_INP + SW; CW = $clog2(MAX_OUTST+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- s_ar_valid_i  in  N_SRC  per-source AR valid.
- s_ar_ready_o  out  N_SRC  per-source AR ready.
- s_ar_id_i  in  N_SRC*IW_INP  per-source AR ID.
- s_ar_addr_i  in  N_SRC*AW  per-source AR address.
- s_ar_len_i  in  N_SRC*8  per-source burst length.
- s_ar_size_i  in  N_SRC*3  per-source burst size.
- s_ar_burst_i  in  N_SRC*2  per-source burst type.
- m_ar_valid_o  out  1  merged AR valid.
- m_ar_ready_i  in  1  merged AR ready.
- m_ar_id_o  out  IW_OUP  {source index, source ID}.
- m_ar_addr_o/len_o/size_o/burst_o  out  AW/8/3/2  granted payload.
- m_r_valid_i  in  1  R valid.
- m_r_ready_o  out  1  R ready.
- m_r_id_i  in  IW_OUP  R ID.
- m_r_data_i  in  DW  R data.
- m_r_resp_i  in  2  R response.
- m_r_last_i  in  1  R last.
- s_r_valid_o  out  N_SRC  per-source R valid.
- s_r_ready_i  in  N_SRC  per-source R ready.
- s_r_id_o  out  IW_INP  R ID with source bits stripped (shared by all sources).
- s_r_data_o/resp_o/last_o  out  DW/2/1  R payload (shared by all sources).
- busy_o  out  1  any outstanding burst.
- err_o  out  1  sticky: R beat carried an illegal source index.

Behaviour:
- Eligibility: source i is eligible when s_ar_valid_i[i] is high and cnt[i] < MAX_OUTST.
- Arbitration: round-robin from pointer ptr. The first eligible index at or after ptr, wrapping, wins. Combinational when no grant is locked.
- Lock: if m_ar_valid_o is high and m_ar_ready_i is low, a lock flag freezes the granted index until the handshake. The lock guarantees AXI valid/payload stability; a newly eligible higher-priority source does not preempt.
- On AR handshake from source g: ptr <= (g+1) mod N_SRC; lock clears; s_ar_ready_o[g] = m_ar_ready_i. All other s_ar_ready_o bits are 0.
- m_ar_id_o = {g[SW-1:0], s_ar_id[g]}. Zero-cycle latency with the optional feature off.
- R routing:
  - src = m_r_id_i[IW_OUP-1:IW_INP]; s_r_valid_o[src] = m_r_valid_i; m_r_ready_o = s_r_ready_i[src].
  - s_r_id_o = m_r_id_i[IW_INP-1:0]; data, resp and last pass through combinationally.
  - If src >= N_SRC: m_r_ready_o = 1, the beat is dropped, and err_o sets until reset.
- Counters cnt[i] (CW bits):
  - +1 on AR handshake of i; −1 on R handshake of i with m_r_last_i.
  - Both in the same cycle: unchanged.
  - Saturates at MAX_OUTST; the source is masked from eligibility and its ready is 0.
  - Decrement at 0 (protocol violation) holds at 0 and sets err_o.
- busy_o = OR over all (cnt[i] != 0), registered-free, combinational from the counters.
- Reset values: ptr = 0, lock = 0, all cnt = 0, err_o = 0. All ready/valid outputs are 0 while in reset; payload outputs are don't-care.
- Reset mid-burst: counters clear immediately. Upstream is responsible for not issuing R beats for pre-reset transactions.

Optional Feature:
- Macro: SOC_NODE_RD_ARB_AR_SPILL_EN.
- Defined: a two-entry spill register is inserted on the merged AR output.
  - m_ar_* is registered, adding 1 cycle of AR latency.
  - s_ar_ready_o[g] = spill not full; full throughput is sustained.
  - Lock is unnecessary because the payload is held in the spill register.
  - Counters increment on the upstream (source-side) handshake.
  - All spill entries are invalid after reset.
- Undefined: combinational path, behaviour as above.

Test Plan:
- Rotation: sources 0..3 assert AR continuously with m_ar_ready_i = 1 → grants 0,1,2,3,0 on consecutive cycles; m_ar_id_o[7:6] follows 0,1,2,3.
- Lock: source 2 granted, m_ar_ready_i = 0 for 5 cycles, then source 1 asserts → m_ar_id/addr stay on source 2 until ready. Source 1 is granted the cycle after the handshake only if ptr reaches it; ptr = 3, so the order is 3 if valid, else 0, else 1.
- Outstanding limit: MAX_OUTST = 2, source 0 issues 3 ARs with no R → third AR stalls (s_ar_ready_o[0] = 0). One R with last for ID {0,x} → third AR is accepted next cycle; busy_o stays 1 until both remaining bursts return.
- R routing: R beats with m_r_id_i = {2'd3, 6'h15}, len 3 → s_r_valid_o = 4'b1000 on all 4 beats, s_r_id_o = 6'h15. s_r_ready_i[3] backpressure propagates to m_r_ready_o; cnt[3] decrements only on the last beat.
- Simultaneous: AR handshake and R last for source 1 in the same cycle → cnt[1] unchanged. N_SRC = 3 and an R with source bits 3 → m_r_ready_o = 1, err_o = 1 sticky.
- Async reset asserted mid-burst → all s_ar_ready_o/s_r_valid_o drop without a clock edge; after release ptr = 0 and busy_o = 0.

Source files
------------

// File: rtl/soc_node_rd_arbiter.sv
// soc_node_rd_arbiter
// Round-robin arbiter that merges N_SRC AXI read-address channels onto one
// AR port and routes the returning R beats back by the source index carried
// in the upper ID bits. Each source has a counter of outstanding bursts that
// masks it from arbitration when full.
//
// Handshake rule for every channel: a transfer happens in the cycle where
// valid and ready are both high; a valid that is raised stays high with a
// stable payload until that transfer.
//
// Optional build macro: SOC_NODE_RD_ARB_AR_SPILL_EN inserts a two-entry spill
// register on the merged AR output (one extra cycle of AR latency, no lock).
module soc_node_rd_arbiter #(
    parameter int N_SRC     = 4,
    parameter int IW_INP    = 6,
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int MAX_OUTST = 8,
    localparam int SW       = $clog2(N_SRC),
    localparam int IW_OUP   = IW_INP + SW,
    localparam int CW       = $clog2(MAX_OUTST + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SRC-1:0]      s_ar_valid_i,
    output logic [N_SRC-1:0]      s_ar_ready_o,
    input  logic [N_SRC*IW_INP-1:0] s_ar_id_i,
    input  logic [N_SRC*AW-1:0]   s_ar_addr_i,
    input  logic [N_SRC*8-1:0]    s_ar_len_i,
    input  logic [N_SRC*3-1:0]    s_ar_size_i,
    input  logic [N_SRC*2-1:0]    s_ar_burst_i,
    output logic                  m_ar_valid_o,
    input  logic                  m_ar_ready_i,
    output logic [IW_OUP-1:0]     m_ar_id_o,
    output logic [AW-1:0]         m_ar_addr_o,
    output logic [7:0]            m_ar_len_o,
    output logic [2:0]            m_ar_size_o,
    output logic [1:0]            m_ar_burst_o,
    input  logic                  m_r_valid_i,
    output logic                  m_r_ready_o,
    input  logic [IW_OUP-1:0]     m_r_id_i,
    input  logic [DW-1:0]         m_r_data_i,
    input  logic [1:0]            m_r_resp_i,
    input  logic                  m_r_last_i,
    output logic [N_SRC-1:0]      s_r_valid_o,
    input  logic [N_SRC-1:0]      s_r_ready_i,
    output logic [IW_INP-1:0]     s_r_id_o,
    output logic [DW-1:0]         s_r_data_o,
    output logic [1:0]            s_r_resp_o,
    output logic                  s_r_last_o,
    output logic                  busy_o,
    output logic                  err_o
);

    logic [SW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q [N_SRC];
    logic             err_q;

    logic [N_SRC-1:0] elig;
    logic [SW-1:0]    rr_idx [N_SRC];
    logic [SW-1:0]    arb_idx;
    logic             arb_found;
    logic [SW-1:0]    gnt_idx;
    logic [N_SRC-1:0] ar_hs;
    logic             up_fire;

    logic [IW_INP-1:0] sel_id;
    logic [AW-1:0]     sel_addr;
    logic [7:0]        sel_len;
    logic [2:0]        sel_size;
    logic [1:0]        sel_burst;

    logic [SW-1:0]    r_src;
    logic             r_src_ok;
    logic             r_sel_ready;
    logic             r_fire;
    logic [N_SRC-1:0] r_dec;
    logic [N_SRC-1:0] dec_at_zero;

    // Eligibility: source requesting and not at its outstanding limit
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = s_ar_valid_i[i] && (cnt_q[i] < CW'(MAX_OUTST));
        end
    end

    // Candidate order for the round-robin search, starting at ptr
    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            rr_idx[k] = SW'((int'(ptr_q) + k) % N_SRC);
        end
    end

    // First eligible source at or after ptr, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!arb_found && elig[rr_idx[k]]) begin
                arb_found = 1'b1;
                arb_idx   = rr_idx[k];
            end
        end
    end

    // Payload of the granted source
    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_idx == SW'(i)) begin
                sel_id    = s_ar_id_i[i*IW_INP +: IW_INP];
                sel_addr  = s_ar_addr_i[i*AW +: AW];
                sel_len   = s_ar_len_i[i*8 +: 8];
                sel_size  = s_ar_size_i[i*3 +: 3];
                sel_burst = s_ar_burst_i[i*2 +: 2];
            end
        end
    end

`ifdef SOC_NODE_RD_ARB_AR_SPILL_EN
    localparam int PW = IW_OUP + AW + 8 + 3 + 2;

    logic [PW-1:0] sp_data_q [2];
    logic          sp_wr_q;
    logic          sp_rd_q;
    logic [1:0]    sp_cnt_q;
    logic          sp_full;
    logic          sp_pop;

    // The spill register holds the payload, so the grant follows the arbiter
    assign gnt_idx      = arb_idx;
    assign sp_full      = (sp_cnt_q == 2'd2);
    assign m_ar_valid_o = rst_ni && (sp_cnt_q != 2'd0);
    assign sp_pop       = m_ar_valid_o && m_ar_ready_i;
    assign {m_ar_id_o, m_ar_addr_o, m_ar_len_o, m_ar_size_o, m_ar_burst_o} = sp_data_q[sp_rd_q];

    // Upstream ready: granted source may push whenever the spill has room
    always_comb begin
        s_ar_ready_o = '0;
        for (int i = 0; i < N_SRC; i++) begin
            s_ar_ready_o[i] = rst_ni && arb_found && !sp_full && (gnt_idx == SW'(i));
        end
    end

    // Two-entry spill FIFO: push on upstream handshake, pop on downstream
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_wr_q      <= 1'b0;
            sp_rd_q      <= 1'b0;
            sp_cnt_q     <= 2'd0;
            sp_data_q[0] <= '0;
            sp_data_q[1] <= '0;
        end else begin
            if (up_fire) begin
                sp_data_q[sp_wr_q] <= {gnt_idx, sel_id, sel_addr, sel_len, sel_size, sel_burst};
                sp_wr_q            <= ~sp_wr_q;
            end
            if (sp_pop) begin
                sp_rd_q <= ~sp_rd_q;
            end
            if (up_fire && !sp_pop) begin
                sp_cnt_q <= sp_cnt_q + 2'd1;
            end else if (!up_fire && sp_pop) begin
                sp_cnt_q <= sp_cnt_q - 2'd1;
            end
        end
    end
`else
    logic          lock_q;
    logic [SW-1:0] lock_idx_q;

    // While a grant is pending the index is frozen so valid/payload stay stable
    assign gnt_idx      = lock_q ? lock_idx_q : arb_idx;
    assign m_ar_valid_o = rst_ni && (lock_q || arb_found);
    assign m_ar_id_o    = {gnt_idx, sel_id};
    assign m_ar_addr_o  = sel_addr;
    assign m_ar_len_o   = sel_len;
    assign m_ar_size_o  = sel_size;
    assign m_ar_burst_o = sel_burst;

    // Downstream ready is forwarded only to the granted source
    always_comb begin
        s_ar_ready_o = '0;
        for (int i = 0; i < N_SRC; i++) begin
            s_ar_ready_o[i] = m_ar_valid_o && m_ar_ready_i && (gnt_idx == SW'(i));
        end
    end

    // Lock on a stalled grant, release on the handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q <= m_ar_valid_o && !m_ar_ready_i;
            if (!lock_q) begin
                lock_idx_q <= arb_idx;
            end
        end
    end
`endif

    // Per-source AR handshakes (upstream side) drive counters and pointer
    always_comb begin
        ar_hs = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ar_hs[i] = s_ar_valid_i[i] && s_ar_ready_o[i];
        end
    end
    assign up_fire = |ar_hs;

    // Round-robin pointer moves just past the source that was accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (up_fire) begin
            ptr_q <= SW'((int'(gnt_idx) + 1) % N_SRC);
        end
    end

    // R routing by the source index held in the ID MSBs
    assign r_src    = m_r_id_i[IW_OUP-1:IW_INP];
    assign r_src_ok = (int'(r_src) < N_SRC);

    // Steer valid to the addressed source and take its ready; unknown
    // sources get ready=1 so the beat is consumed and dropped
    always_comb begin
        s_r_valid_o = '0;
        r_sel_ready = 1'b1;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_src == SW'(i)) begin
                s_r_valid_o[i] = rst_ni && m_r_valid_i;
                r_sel_ready    = s_r_ready_i[i];
            end
        end
    end

    assign m_r_ready_o = rst_ni && r_sel_ready;
    assign s_r_id_o    = m_r_id_i[IW_INP-1:0];
    assign s_r_data_o  = m_r_data_i;
    assign s_r_resp_o  = m_r_resp_i;
    assign s_r_last_o  = m_r_last_i;
    assign r_fire      = m_r_valid_i && m_r_ready_o;

    // Last-beat handshakes retire one burst of the addressed source
    always_comb begin
        r_dec       = '0;
        dec_at_zero = '0;
        for (int i = 0; i < N_SRC; i++) begin
            r_dec[i]       = r_fire && m_r_last_i && r_src_ok && (r_src == SW'(i));
            dec_at_zero[i] = r_dec[i] && !ar_hs[i] && (cnt_q[i] == '0);
        end
    end

    // Outstanding counters: simultaneous inc/dec cancel, never wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (ar_hs[i] && !r_dec[i]) begin
                    if (cnt_q[i] != CW'(MAX_OUTST)) begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else if (!ar_hs[i] && r_dec[i]) begin
                    if (cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - CW'(1);
                    end
                end
            end
        end
    end

    // Sticky error: beat for an unknown source or retire with nothing open
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((m_r_valid_i && !r_src_ok) || (|dec_at_zero)) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;

    // Busy whenever any source has a burst in flight
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            busy_o = busy_o || (cnt_q[i] != '0);
        end
    end

endmodule
